// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the 8051 timer/counter SFR controller.
//   - SFR addresses of TCON, TMOD, TL0, TL1, TH0, TH1
//   - TCON bit positions and TMOD per-nibble bit positions
//   - timer mode encodings (M1:M0)
//   - default machine-cycle divider
package timer_pkg;

    localparam logic [7:0] ADDR_TCON = 8'h88;
    localparam logic [7:0] ADDR_TMOD = 8'h89;
    localparam logic [7:0] ADDR_TL0  = 8'h8A;
    localparam logic [7:0] ADDR_TL1  = 8'h8B;
    localparam logic [7:0] ADDR_TH0  = 8'h8C;
    localparam logic [7:0] ADDR_TH1  = 8'h8D;

    localparam int unsigned TCON_TF1 = 7;
    localparam int unsigned TCON_TR1 = 6;
    localparam int unsigned TCON_TF0 = 5;
    localparam int unsigned TCON_TR0 = 4;
    localparam int unsigned TCON_IE1 = 3;
    localparam int unsigned TCON_IT1 = 2;
    localparam int unsigned TCON_IE0 = 1;
    localparam int unsigned TCON_IT0 = 0;

    // Bit positions inside one TMOD nibble {GATE, C/T, M1, M0}
    localparam int unsigned TMOD_GATE = 3;
    localparam int unsigned TMOD_CT   = 2;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } timer_mode_e;

    localparam int unsigned CLK_DIV_DEFAULT = 12;

endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: SFR bus between the CPU core and the timer controller.
//   sfr_addr  : SFR address
//   sfr_wr    : one-clk write strobe
//   sfr_wdata : write data
//   sfr_rdata : combinational read data (0 for unmapped addresses)
// Modports: master (CPU side), slave (timer_ctrl side).
interface timer_ctrl_if;

    logic [7:0] sfr_addr;
    logic       sfr_wr;
    logic [7:0] sfr_wdata;
    logic [7:0] sfr_rdata;

    modport master (
        output sfr_addr,
        output sfr_wr,
        output sfr_wdata,
        input  sfr_rdata
    );

    modport slave (
        input  sfr_addr,
        input  sfr_wr,
        input  sfr_wdata,
        output sfr_rdata
    );

endinterface

// File: rtl/timer_pin_sync.sv
// timer_pin_sync: multi-flop synchronizer for one asynchronous pin plus a
// registered falling-edge detect.
//   clk, rst_n : clock, synchronous active-low reset
//   pin        : asynchronous input
//   sync       : synchronized pin value (last stage)
//   fall       : high for one clk when sync goes 1 -> 0
// All flops reset to RESET_VAL so an idle pin produces no edge after reset.
module timer_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sync,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stages <= {SYNC_STAGES{RESET_VAL}};
            prev   <= RESET_VAL;
        end else begin
            stages[0] <= pin;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
            prev <= stages[SYNC_STAGES-1];
        end
    end

    assign sync = stages[SYNC_STAGES-1];
    assign fall = prev & ~sync;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: SFR-side controller for the two 8051 timer/counter datapaths.
// Holds TMOD, TCON, TH0/TL0/TH1/TL1, generates the machine-cycle tick, gates
// each datapath's run, commits datapath next-values and manages TF0/TF1.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   sfr                        SFR bus (timer_ctrl_if.slave)
//   t0_pin, t1_pin             async external count inputs
//   int0_n, int1_n             async external interrupt / gate pins
//   tX_run, tX_mode            run enable and {C/T, M1, M0} to datapath X
//   tX_cnt_sig                 synchronized count pin to datapath X
//   tX_th, tX_tl               current count registers
//   tX_th_nxt, tX_tl_nxt       datapath next values
//   tX_ovf                     datapath terminal-count flag
//   irq_t0/1, ack_t0/1         timer interrupt request / acknowledge
// Optional macro TIMER_EXT_INT_EN: enables TCON[3:0] = {IE1, IT1, IE0, IT0}
// and adds ports ack_ex0/1 (in) and irq_ex0/1 (out).
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CLK_DIV     = CLK_DIV_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    timer_ctrl_if.slave  sfr,
    input  logic         t0_pin,
    input  logic         t1_pin,
    input  logic         int0_n,
    input  logic         int1_n,
    output logic         t0_run,
    output logic [2:0]   t0_mode,
    output logic         t0_cnt_sig,
    output logic [7:0]   t0_th,
    output logic [7:0]   t0_tl,
    input  logic [7:0]   t0_th_nxt,
    input  logic [7:0]   t0_tl_nxt,
    input  logic         t0_ovf,
    output logic         t1_run,
    output logic [2:0]   t1_mode,
    output logic         t1_cnt_sig,
    output logic [7:0]   t1_th,
    output logic [7:0]   t1_tl,
    input  logic [7:0]   t1_th_nxt,
    input  logic [7:0]   t1_tl_nxt,
    input  logic         t1_ovf,
    output logic         irq_t0,
    output logic         irq_t1,
    input  logic         ack_t0,
    input  logic         ack_t1
`ifdef TIMER_EXT_INT_EN
    ,
    input  logic         ack_ex0,
    input  logic         ack_ex1,
    output logic         irq_ex0,
    output logic         irq_ex1
`endif
);

    localparam logic [7:0] PRE_LAST = 8'(CLK_DIV - 1);

    logic [7:0] tmod;
    logic [1:0] tr;
    logic [1:0] tf;
    logic [7:0] th [2];
    logic [7:0] tl [2];
    logic [7:0] pre_cnt;
    logic       tick;

    logic [7:0] th_nxt [2];
    logic [7:0] tl_nxt [2];
    logic [3:0] nib    [2];
    logic [1:0] ovf;
    logic [1:0] ack;
    logic [1:0] int_sync_n;
    logic [1:0] run;
    logic [1:0] commit;

    logic       wr_tcon;
    logic       wr_tmod;
    logic [1:0] wr_th;
    logic [1:0] wr_tl;
    logic [1:0] wr_tf_val;
    logic [1:0] wr_tr_val;
    logic [3:0] tcon_lo;

    assign th_nxt[0] = t0_th_nxt;
    assign th_nxt[1] = t1_th_nxt;
    assign tl_nxt[0] = t0_tl_nxt;
    assign tl_nxt[1] = t1_tl_nxt;
    assign nib[0]    = tmod[3:0];
    assign nib[1]    = tmod[7:4];
    assign ovf       = {t1_ovf, t0_ovf};
    assign ack       = {ack_t1, ack_t0};

    assign wr_tcon   = sfr.sfr_wr && (sfr.sfr_addr == ADDR_TCON);
    assign wr_tmod   = sfr.sfr_wr && (sfr.sfr_addr == ADDR_TMOD);
    assign wr_th     = {sfr.sfr_wr && (sfr.sfr_addr == ADDR_TH1),
                        sfr.sfr_wr && (sfr.sfr_addr == ADDR_TH0)};
    assign wr_tl     = {sfr.sfr_wr && (sfr.sfr_addr == ADDR_TL1),
                        sfr.sfr_wr && (sfr.sfr_addr == ADDR_TL0)};
    assign wr_tf_val = {sfr.sfr_wdata[TCON_TF1], sfr.sfr_wdata[TCON_TF0]};
    assign wr_tr_val = {sfr.sfr_wdata[TCON_TR1], sfr.sfr_wdata[TCON_TR0]};

    // ---------------------------------------------------------------
    // Pin synchronizers: count pins idle low, interrupt pins idle high
    // ---------------------------------------------------------------
`ifdef TIMER_EXT_INT_EN
    logic [1:0] int_fall;
`endif

    timer_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_t0 (
        .clk(clk), .rst_n(rst_n), .pin(t0_pin), .sync(t0_cnt_sig), .fall()
    );

    timer_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_t1 (
        .clk(clk), .rst_n(rst_n), .pin(t1_pin), .sync(t1_cnt_sig), .fall()
    );

    timer_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_int0 (
        .clk(clk), .rst_n(rst_n), .pin(int0_n), .sync(int_sync_n[0]),
`ifdef TIMER_EXT_INT_EN
        .fall(int_fall[0])
`else
        .fall()
`endif
    );

    timer_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_int1 (
        .clk(clk), .rst_n(rst_n), .pin(int1_n), .sync(int_sync_n[1]),
`ifdef TIMER_EXT_INT_EN
        .fall(int_fall[1])
`else
        .fall()
`endif
    );

    // ---------------------------------------------------------------
    // Machine-cycle prescaler: free-running, independent of TRx
    // ---------------------------------------------------------------
    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

    // ---------------------------------------------------------------
    // Run gating and commit enable (mode 3 treated as stopped)
    // ---------------------------------------------------------------
    always_comb begin
        run    = '0;
        commit = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            run[i] = tr[i] & (~nib[i][TMOD_GATE] | ~int_sync_n[i]) &
                     (timer_mode_e'(nib[i][1:0]) != MODE3);
            commit[i] = run[i] & (nib[i][TMOD_CT] | tick);
        end
    end

    // ---------------------------------------------------------------
    // SFR state. A byte write wins over commit for that byte only;
    // overflow set wins over both ack and a software write to TF.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmod <= '0;
            tr   <= '0;
            tf   <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                th[i] <= '0;
                tl[i] <= '0;
            end
        end else begin
            if (wr_tmod) begin
                tmod <= sfr.sfr_wdata;
            end
            if (wr_tcon) begin
                tr <= wr_tr_val;
            end
            for (int unsigned i = 0; i < 2; i++) begin
                if (wr_th[i]) begin
                    th[i] <= sfr.sfr_wdata;
                end else if (commit[i]) begin
                    th[i] <= th_nxt[i];
                end
                if (wr_tl[i]) begin
                    tl[i] <= sfr.sfr_wdata;
                end else if (commit[i]) begin
                    tl[i] <= tl_nxt[i];
                end
                if (commit[i] && ovf[i]) begin
                    tf[i] <= 1'b1;
                end else if (ack[i]) begin
                    tf[i] <= 1'b0;
                end else if (wr_tcon) begin
                    tf[i] <= wr_tf_val[i];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // External interrupt flags (optional)
    // ---------------------------------------------------------------
`ifdef TIMER_EXT_INT_EN
    logic [1:0] ie;
    logic [1:0] it;
    logic [1:0] ack_ex;
    logic [1:0] wr_ie_val;
    logic [1:0] wr_it_val;

    assign ack_ex    = {ack_ex1, ack_ex0};
    assign wr_ie_val = {sfr.sfr_wdata[TCON_IE1], sfr.sfr_wdata[TCON_IE0]};
    assign wr_it_val = {sfr.sfr_wdata[TCON_IT1], sfr.sfr_wdata[TCON_IT0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie <= '0;
            it <= '0;
        end else begin
            if (wr_tcon) begin
                it <= wr_it_val;
            end
            for (int unsigned i = 0; i < 2; i++) begin
                if (it[i]) begin
                    if (int_fall[i]) begin
                        ie[i] <= 1'b1;
                    end else if (ack_ex[i]) begin
                        ie[i] <= 1'b0;
                    end else if (wr_tcon) begin
                        ie[i] <= wr_ie_val[i];
                    end
                end else begin
                    // Level mode: flag mirrors the synchronized pin level.
                    ie[i] <= ~int_sync_n[i];
                end
            end
        end
    end

    assign tcon_lo = {ie[1], it[1], ie[0], it[0]};
    assign irq_ex0 = ie[0];
    assign irq_ex1 = ie[1];
`else
    assign tcon_lo = '0;
`endif

    // ---------------------------------------------------------------
    // SFR read mux
    // ---------------------------------------------------------------
    always_comb begin
        sfr.sfr_rdata = '0;
        case (sfr.sfr_addr)
            ADDR_TCON: sfr.sfr_rdata = {tf[1], tr[1], tf[0], tr[0], tcon_lo};
            ADDR_TMOD: sfr.sfr_rdata = tmod;
            ADDR_TL0:  sfr.sfr_rdata = tl[0];
            ADDR_TL1:  sfr.sfr_rdata = tl[1];
            ADDR_TH0:  sfr.sfr_rdata = th[0];
            ADDR_TH1:  sfr.sfr_rdata = th[1];
            default:   sfr.sfr_rdata = '0;
        endcase
    end

    assign t0_run  = run[0];
    assign t1_run  = run[1];
    assign t0_mode = tmod[2:0];
    assign t1_mode = tmod[6:4];
    assign t0_th   = th[0];
    assign t0_tl   = tl[0];
    assign t1_th   = th[1];
    assign t1_tl   = tl[1];
    assign irq_t0  = tf[0];
    assign irq_t1  = tf[1];

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: randomized and directed self-checking bench for timer_ctrl.
// The bench plays the CPU (SFR bus), the two datapaths and the interrupt
// controller; a cycle-count based reference model predicts every output.
// Optional macro TIMER_EXT_INT_EN: also exercises IE0/IE1.
module tb_timer_ctrl;
    import timer_pkg::*;

    localparam int unsigned CLK_DIV     = 12;
    localparam int unsigned SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timer_ctrl_if sfr ();

    logic [1:0] pin, int_n, ack, ovf, run, cnt_sig, irq;
    logic [7:0] th_nxt [2];
    logic [7:0] tl_nxt [2];
    logic [7:0] th_o   [2];
    logic [7:0] tl_o   [2];
    logic [2:0] mode_o [2];
`ifdef TIMER_EXT_INT_EN
    logic [1:0] ack_ex, irq_ex;
`endif

    timer_ctrl #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .sfr(sfr.slave),
        .t0_pin(pin[0]), .t1_pin(pin[1]), .int0_n(int_n[0]), .int1_n(int_n[1]),
        .t0_run(run[0]), .t0_mode(mode_o[0]), .t0_cnt_sig(cnt_sig[0]),
        .t0_th(th_o[0]), .t0_tl(tl_o[0]), .t0_th_nxt(th_nxt[0]), .t0_tl_nxt(tl_nxt[0]),
        .t0_ovf(ovf[0]),
        .t1_run(run[1]), .t1_mode(mode_o[1]), .t1_cnt_sig(cnt_sig[1]),
        .t1_th(th_o[1]), .t1_tl(tl_o[1]), .t1_th_nxt(th_nxt[1]), .t1_tl_nxt(tl_nxt[1]),
        .t1_ovf(ovf[1]),
        .irq_t0(irq[0]), .irq_t1(irq[1]), .ack_t0(ack[0]), .ack_t1(ack[1])
`ifdef TIMER_EXT_INT_EN
        , .ack_ex0(ack_ex[0]), .ack_ex1(ack_ex[1]), .irq_ex0(irq_ex[0]), .irq_ex1(irq_ex[1])
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [7:0]  m_tmod;
    bit   [1:0]  m_tr, m_tf, m_ie, m_it;
    logic [7:0]  m_th [2];
    logic [7:0]  m_tl [2];
    int unsigned m_cyc;
    // Input history per pin, bit 0 = value presented before the latest edge
    bit   [15:0] h_pin [2];
    bit   [15:0] h_int [2];
    bit          dp_auto;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_nib(input int x);
        return (x == 0) ? m_tmod[3:0] : m_tmod[7:4];
    endfunction

    function automatic bit m_int_sync(input int x);
        return h_int[x][SYNC_STAGES-1];
    endfunction

    function automatic bit m_run(input int x);
        logic [3:0] n;
        n = m_nib(x);
        return m_tr[x] && (!n[3] || !m_int_sync(x)) && (n[1:0] != 2'd3);
    endfunction

    function automatic logic [7:0] m_rd(input logic [7:0] a);
        logic [3:0] lo;
`ifdef TIMER_EXT_INT_EN
        lo = {m_ie[1], m_it[1], m_ie[0], m_it[0]};
`else
        lo = 4'h0;
`endif
        case (a)
            8'h88:   return {m_tf[1], m_tr[1], m_tf[0], m_tr[0], lo};
            8'h89:   return m_tmod;
            8'h8A:   return m_tl[0];
            8'h8B:   return m_tl[1];
            8'h8C:   return m_th[0];
            8'h8D:   return m_th[1];
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_tmod = 8'h00; m_tr = '0; m_tf = '0; m_ie = '0; m_it = '0; m_cyc = 0;
        for (int x = 0; x < 2; x++) begin
            m_th[x] = 8'h00; m_tl[x] = 8'h00;
            h_pin[x] = '0; h_int[x] = '1;
        end
    endtask

    // Advances the model across one rising edge using current bench inputs.
    task automatic model_edge();
        bit tick;
        bit [1:0] commit;
        bit wr_tcon;
        tick = (m_cyc % CLK_DIV) == (CLK_DIV - 1);
        wr_tcon = sfr.sfr_wr && sfr.sfr_addr == 8'h88;
        for (int x = 0; x < 2; x++) begin
            logic [3:0] n;
            n = m_nib(x);
            commit[x] = m_run(x) && (n[2] || tick);
        end
        for (int x = 0; x < 2; x++) begin
            logic [7:0] a_th, a_tl;
            a_th = (x == 0) ? 8'h8C : 8'h8D;
            a_tl = (x == 0) ? 8'h8A : 8'h8B;
`ifdef TIMER_EXT_INT_EN
            if (m_it[x]) begin
                if (h_int[x][SYNC_STAGES] && !h_int[x][SYNC_STAGES-1]) m_ie[x] = 1'b1;
                else if (ack_ex[x]) m_ie[x] = 1'b0;
                else if (wr_tcon) m_ie[x] = sfr.sfr_wdata[x == 0 ? 1 : 3];
            end else begin
                m_ie[x] = !m_int_sync(x);
            end
`endif
            if (sfr.sfr_wr && sfr.sfr_addr == a_th) m_th[x] = sfr.sfr_wdata;
            else if (commit[x]) m_th[x] = th_nxt[x];
            if (sfr.sfr_wr && sfr.sfr_addr == a_tl) m_tl[x] = sfr.sfr_wdata;
            else if (commit[x]) m_tl[x] = tl_nxt[x];
            if (commit[x] && ovf[x]) m_tf[x] = 1'b1;
            else if (ack[x]) m_tf[x] = 1'b0;
            else if (wr_tcon) m_tf[x] = sfr.sfr_wdata[x == 0 ? 5 : 7];
        end
        if (wr_tcon) begin
            m_tr = {sfr.sfr_wdata[6], sfr.sfr_wdata[4]};
`ifdef TIMER_EXT_INT_EN
            m_it = {sfr.sfr_wdata[2], sfr.sfr_wdata[0]};
`endif
        end
        if (sfr.sfr_wr && sfr.sfr_addr == 8'h89) m_tmod = sfr.sfr_wdata;
        m_cyc++;
        for (int x = 0; x < 2; x++) begin
            h_pin[x] = {h_pin[x][14:0], pin[x]};
            h_int[x] = {h_int[x][14:0], int_n[x]};
        end
    endtask

    task automatic compare_all();
        for (int x = 0; x < 2; x++) begin
            logic [3:0] n;
            n = m_nib(x);
            chk($sformatf("run%0d", x), run[x], m_run(x));
            chk($sformatf("mode%0d", x), mode_o[x], n[2:0]);
            chk($sformatf("cnt_sig%0d", x), cnt_sig[x], h_pin[x][SYNC_STAGES-1]);
            chk($sformatf("th%0d", x), th_o[x], m_th[x]);
            chk($sformatf("tl%0d", x), tl_o[x], m_tl[x]);
            chk($sformatf("irq_t%0d", x), irq[x], m_tf[x]);
`ifdef TIMER_EXT_INT_EN
            chk($sformatf("irq_ex%0d", x), irq_ex[x], m_ie[x]);
`endif
        end
        chk("rdata", sfr.sfr_rdata, m_rd(sfr.sfr_addr));
    endtask

    task automatic step();
        if (dp_auto) begin
            for (int x = 0; x < 2; x++) begin
                tl_nxt[x] = m_tl[x] + 8'd1;
                th_nxt[x] = (m_tl[x] == 8'hFF) ? m_th[x] + 8'd1 : m_th[x];
            end
        end
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        sfr.sfr_wr = 1'b1; sfr.sfr_addr = a; sfr.sfr_wdata = d;
        step();
        sfr.sfr_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sfr.sfr_wr = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        compare_all();
    endtask

    initial begin
        logic [7:0] prev;
        int unsigned changes, last_chg, found;

        sfr.sfr_addr = 8'h00; sfr.sfr_wr = 1'b0; sfr.sfr_wdata = 8'h00;
        pin = '0; int_n = '1; ack = '0; ovf = '0; dp_auto = 1'b1;
        for (int x = 0; x < 2; x++) begin th_nxt[x] = 8'h00; tl_nxt[x] = 8'h00; end
`ifdef TIMER_EXT_INT_EN
        ack_ex = '0;
`endif
        do_reset();
        do_reset();

        // Reset state with fixed expectations
        for (int a = 8'h88; a <= 8'h8D; a++) begin
            sfr.sfr_addr = 8'(a);
            #1;
            chk($sformatf("reset_rd_%02h", a), sfr.sfr_rdata, 8'h00);
        end
        chk("reset_irq", {6'd0, irq}, 8'h00);
        chk("reset_run", {6'd0, run}, 8'h00);

        // Timer mode: TL0 moves exactly once per CLK_DIV clocks
        sfr_write(ADDR_TMOD, 8'h01);
        sfr_write(ADDR_TH0, 8'h05);
        sfr_write(ADDR_TL0, 8'h05);
        sfr_write(ADDR_TCON, 8'h10);
        sfr.sfr_addr = ADDR_TL0;
        prev = tl_o[0]; changes = 0; last_chg = 0;
        for (int unsigned i = 1; i <= 4 * CLK_DIV; i++) begin
            step();
            if (tl_o[0] !== prev) begin
                if (changes > 0) chk("tick_gap", 8'(i - last_chg), 8'(CLK_DIV));
                changes++; last_chg = i;
            end
            prev = tl_o[0];
        end
        chk("tl0_updates", 8'(changes), 8'd4);

        ovf[0] = 1'b1; found = 0;
        for (int unsigned i = 0; i <= CLK_DIV && found == 0; i++) begin
            step();
            if (tl_o[0] !== prev) found = 1;
            else chk("irq_before_ovf", {7'd0, irq[0]}, 8'h00);
            prev = tl_o[0];
        end
        if (found == 0) chk("ovf_commit_timeout", 8'h00, 8'h01);
        chk("irq_after_ovf", {7'd0, irq[0]}, 8'h01);
        ovf[0] = 1'b0;
        sfr_write(ADDR_TCON, 8'h00);
        chk("tf0_sw_clear", {7'd0, irq[0]}, 8'h00);

        // Gate: no commits while int0_n high, then run after synchronizer
        sfr_write(ADDR_TMOD, 8'h09);
        sfr_write(ADDR_TCON, 8'h10);
        prev = tl_o[0]; changes = 0;
        repeat (3 * CLK_DIV) begin
            step();
            if (tl_o[0] !== prev) changes++;
            prev = tl_o[0];
        end
        chk("gate_no_commit", 8'(changes), 8'd0);
        int_n[0] = 1'b0;
        repeat (SYNC_STAGES - 1) step();
        chk("gate_run_early", {7'd0, run[0]}, 8'h00);
        step();
        chk("gate_run_on", {7'd0, run[0]}, 8'h01);
        repeat (2 * CLK_DIV) step();
        int_n[0] = 1'b1;
        sfr_write(ADDR_TCON, 8'h00);

        // Counter mode: overflow vs ack, commit per clk, byte write priority
        sfr_write(ADDR_TMOD, 8'h05);
        sfr_write(ADDR_TCON, 8'h10);
        ovf[0] = 1'b1; ack[0] = 1'b1;
        step();
        chk("ovf_beats_ack", {7'd0, irq[0]}, 8'h01);
        ovf[0] = 1'b0;
        step();
        chk("ack_clears", {7'd0, irq[0]}, 8'h00);
        ack[0] = 1'b0;
        prev = tl_o[0]; changes = 0;
        repeat (8) begin
            step();
            if (tl_o[0] !== prev) changes++;
            prev = tl_o[0];
        end
        chk("counter_commits", 8'(changes), 8'd8);
        dp_auto = 1'b0;
        th_nxt[0] = 8'h44; tl_nxt[0] = 8'h33;
        sfr_write(ADDR_TL0, 8'hAA);
        chk("wr_beats_commit_tl", tl_o[0], 8'hAA);
        chk("other_byte_commits", th_o[0], 8'h44);
        ovf[0] = 1'b1;
        sfr_write(ADDR_TCON, 8'h10);
        chk("ovf_beats_wr0", {7'd0, irq[0]}, 8'h01);
        ovf[0] = 1'b0;
        sfr_write(ADDR_TCON, 8'h00);

`ifdef TIMER_EXT_INT_EN
        sfr_write(ADDR_TMOD, 8'h00);
        sfr_write(ADDR_TCON, 8'h01);
        int_n[0] = 1'b0;
        repeat (3) step();
        int_n[0] = 1'b1;
        repeat (5) step();
        chk("ie0_edge_held", {7'd0, irq_ex[0]}, 8'h01);
        ack_ex[0] = 1'b1;
        step();
        ack_ex[0] = 1'b0;
        chk("ie0_ack", {7'd0, irq_ex[0]}, 8'h00);
        repeat (5) step();
        chk("ie0_once", {7'd0, irq_ex[0]}, 8'h00);
        sfr_write(ADDR_TCON, 8'h00);
        int_n[0] = 1'b0;
        repeat (SYNC_STAGES + 1) step();
        chk("ie0_level_low", {7'd0, irq_ex[0]}, 8'h01);
        int_n[0] = 1'b1;
        repeat (SYNC_STAGES + 1) step();
        chk("ie0_level_high", {7'd0, irq_ex[0]}, 8'h00);
`endif

        // Randomized phase
        for (int unsigned i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                sfr.sfr_wr    = ($urandom_range(0, 5) == 0);
                sfr.sfr_addr  = 8'(8'h86 + $urandom_range(0, 9));
                sfr.sfr_wdata = 8'($urandom);
                pin   = 2'($urandom);
                ack   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
                ovf   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
                if ($urandom_range(0, 9) == 0) int_n[0] = ~int_n[0];
                if ($urandom_range(0, 9) == 0) int_n[1] = ~int_n[1];
`ifdef TIMER_EXT_INT_EN
                ack_ex = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
`endif
                for (int x = 0; x < 2; x++) begin
                    th_nxt[x] = 8'($urandom);
                    tl_nxt[x] = 8'($urandom);
                end
                step();
            end
        end
        sfr.sfr_wr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- SFR-side controller for the two 8051 timer/counter datapaths (T0, T1).
- Holds TMOD, TCON, TH0/TL0/TH1/TL1 and generates the machine-cycle tick.
- Gates each datapath's run with TRx/GATE/INTx, commits datapath next-values into the count registers, and sets/clears TF0/TF1.
- Drives the interrupt request/acknowledge handshake toward the interrupt controller.

Parameters:
- CLK_DIV, 12, clocks per machine cycle; timer-mode tick period; legal range 1..255.
- SYNC_STAGES, 2, flop stages on each asynchronous pin input (t0_pin, t1_pin, int0_n, int1_n).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sfr_addr  in  8  SFR address
- sfr_wr  in  1  SFR write strobe, one clk
- sfr_wdata  in  8  SFR write data
- sfr_rdata  out  8  SFR read data, combinational from sfr_addr; 0 for unmapped addresses
- t0_pin, t1_pin  in  1  external count inputs (async)
- int0_n, int1_n  in  1  external interrupt / gate pins (async, active-low)
- tX_run  out  1  datapath run enable (X = 0, 1)
- tX_mode  out  3  datapath mode {C/T, M1, M0}
- tX_cnt_sig  out  1  synchronized count pin to datapath
- tX_th, tX_tl  out  8  current count registers to datapath
- tX_th_nxt, tX_tl_nxt  in  8  datapath next values
- tX_ovf  in  1  datapath terminal-count flag
- irq_t0, irq_t1  out  1  interrupt request, equals TF0/TF1
- ack_t0, ack_t1  in  1  one-clk acknowledge from interrupt controller

Behaviour:
- Reset (rst_n=0 at a clk edge): TMOD, TCON, TH0, TL0, TH1 and TL1 all go to 0x00; prescaler goes to 0; synchronizers go to 1 for int*_n and 0 for t*_pin. All outputs therefore read 0, except tX_cnt_sig = 0 after flush. Reset mid-count discards all state.
- SFR map:
  - TCON 0x88: [7]TF1 [6]TR1 [5]TF0 [4]TR0 [3:0] see Optional Feature.
  - TMOD 0x89: [7:4] T1 {GATE, C/T, M1, M0}; [3:0] T0.
  - TL0 0x8A, TL1 0x8B, TH0 0x8C, TH1 0x8D.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick = 1 for one clk when count == CLK_DIV-1.
  - CLK_DIV=1 gives tick every clk.
- Run gating: tX_run = TRx & (~GATEx | intX_sync), where intX_sync = ~synchronized intX_n.
- Commit enable:
  - C/T=0 (timer): commit when tick & tX_run.
  - C/T=1 (counter): commit every clk when tX_run; edge detection is the datapath's job.
- On commit: THx <= tX_th_nxt and TLx <= tX_tl_nxt.
- Overflow:
  - TFx <= 1 when commit & tX_ovf.
  - Mode 3 is treated as stopped: tX_run = 0 and TFx is never set.
- TFx clear: on ackX, or on an SFR write of 0 to the TF bit.
- Priorities (same clk):
  - Overflow set beats ack clear and beats an SFR write of 0.
  - An SFR write to THx/TLx beats commit for that byte; the other byte still commits.
  - A TMOD/TCON write takes effect for the next clk's run/commit decision.
- TR cleared mid-count: the count freezes with no partial-tick carry. The prescaler free-runs and is never reset by TR.
- tX_mode = TMOD nibble [2:0]. irq_tX is registered TFx, so latency from overflow commit to irq is 1 clk.

Optional Feature:
- TIMER_EXT_INT_EN defined:
  - TCON[3:0] = {IE1, IT1, IE0, IT0}.
  - ITx=1: IEx set on a synchronized falling edge of intX_n. ITx=0: IEx follows the level ~intX_n.
  - IEx clears on ack_exX or on a software write of 0.
  - Adds ports ack_ex0, ack_ex1 (in) and irq_ex0, irq_ex1 (out).
- Undefined: TCON[3:0] reads 0, writes are ignored, and those ports are absent.

Decomposition:
- timer_pkg holds:
  - SFR address constants.
  - TCON and TMOD bit-position constants.
  - Mode encodings M0..M3.
  - Default CLK_DIV.
- One sub-module, timer_pin_sync: SYNC_STAGES synchronizer plus registered falling-edge detect. Instantiated once per pin (four instances).

Test Plan:
- Reset then read 0x88..0x8D -> all 0x00; irq_t0 = irq_t1 = 0; tX_run = 0.
- CLK_DIV=12, TMOD=0x01, TH0=TL0=0x05, TR0=1 -> TL0 updates exactly every 12 clks; after tX_ovf commit, TF0 = 1 and irq_t0 = 1 one clk later.
- TMOD=0x09 (GATE0), TR0=1, int0_n=1 -> no commits. Drive int0_n=0 -> commits start after SYNC_STAGES+1 clks.
- Overflow commit in the same clk as ack_t0 -> TF0 stays 1. Ack alone -> TF0 = 0 the next clk.
- SFR write TL0=0xAA in the same clk as a commit -> TL0 = 0xAA while TH0 takes th_nxt. Also verify TMOD=0x05 counter mode commits per clk with run high.
- (TIMER_EXT_INT_EN) IT0=1: pulse int0_n low for 3 clks -> IE0 sets once and holds until ack_ex0. IT0=0: IE0 tracks the level.
